// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, divider FSM encoding, control-unit states
// and the HI/LO source codes driven onto MemToReg.
package cpu_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;
  localparam logic [1:0] DIV_HOLD = 2'd3;

  localparam logic [3:0] CU_FETCH  = 4'd0;
  localparam logic [3:0] CU_DECODE = 4'd1;
  localparam logic [3:0] CU_EXEC   = 4'd2;
  localparam logic [3:0] CU_MEM    = 4'd3;
  localparam logic [3:0] CU_WB     = 4'd4;
  localparam logic [3:0] CU_DIV    = 4'd5;
  localparam logic [3:0] CU_MULT   = 4'd6;
  localparam logic [3:0] CU_EXCP   = 4'd7;

  localparam logic [2:0] MEMTOREG_ALU = 3'd0;
  localparam logic [2:0] MEMTOREG_MEM = 3'd1;
  localparam logic [2:0] MEMTOREG_HI  = 3'd2;
  localparam logic [2:0] MEMTOREG_LO  = 3'd3;

endpackage

// File: rtl/div_unit.sv
// Restoring signed divider, one quotient bit per clock: HI=remainder, LO=quotient.
// DivOut 33 cycles after the start edge; divZero on the start edge when B==0.
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivOut,
  output logic             divZero
);

  localparam int CW = $clog2(WIDTH) + 1;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             divout_q, divout_d;
  logic             divzero_q, divzero_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    divout_d  = 1'b0;
    divzero_d = 1'b0;

    // Remainder stays below |B| <= 2^(WIDTH-1), so its MSB is always free to shift out.
    shifted = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    trial   = {1'b0, shifted} - {1'b0, dvs_q};

    case (state_q)
      DIV_IDLE: begin
        if (DivCtrl) begin
          if (B == '0) begin
            divzero_d = 1'b1;
            state_d   = DIV_HOLD;
          end else begin
            dvd_d   = cond_neg(A, A[WIDTH-1]);
            dvs_d   = cond_neg(B, B[WIDTH-1]);
            qneg_d  = A[WIDTH-1] ^ B[WIDTH-1];
            rneg_d  = A[WIDTH-1];
            rem_d   = '0;
            cnt_d   = '0;
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        if (!DivCtrl) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = trial[WIDTH] ? shifted : trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        lo_d     = cond_neg(dvd_q, qneg_q);
        hi_d     = cond_neg(rem_q, rneg_q);
        divout_d = 1'b1;
        state_d  = DIV_HOLD;
      end
      DIV_HOLD: begin
        if (!DivCtrl) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DIV_IDLE;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      divout_q  <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      divout_q  <= divout_d;
      divzero_q <= divzero_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign DivOut  = divout_q;
  assign divZero = divzero_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed table, reset/abort sequences, random ops vs. an arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        DivCtrl;
  logic [31:0] A, B;
  logic [31:0] HI, LO;
  logic        DivOut, divZero;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .DivCtrl(DivCtrl), .A(A), .B(B),
    .HI(HI), .LO(LO), .DivOut(DivOut), .divZero(divZero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Quotient truncates toward zero, remainder follows the dividend; MIN/-1 wraps.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endfunction

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi, input logic ez);
    int   k;
    logic got_out, got_zero, again;
    @(negedge clk);
    A = a; B = b; DivCtrl = 1'b1;
    @(posedge clk);
    k = 0; got_out = 1'b0; got_zero = 1'b0;
    while (k < 40) begin
      @(negedge clk);
      if (k == 0) begin
        A = $urandom; B = $urandom;
      end
      if (DivOut || divZero) begin
        got_out  = DivOut;
        got_zero = divZero;
        break;
      end
      @(posedge clk);
      k++;
    end
    chk({nm, " latency"}, 32'(k), ez ? 32'd0 : 32'd33);
    chk({nm, " DivOut"}, {31'd0, got_out}, {31'd0, ~ez});
    chk({nm, " divZero"}, {31'd0, got_zero}, {31'd0, ez});
    chk({nm, " LO"}, LO, elo);
    chk({nm, " HI"}, HI, ehi);
    again = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      again = again | DivOut | divZero;
    end
    chk({nm, " pulse held high"}, {31'd0, again}, 32'd0);
    chk({nm, " LO hold"}, LO, elo);
    DivCtrl = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_lo = elo;
    m_hi = ehi;
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{32'd7,          32'd2,          32'd3,          32'd1,          1'b0};
    vecs[1]  = '{32'd5,          32'd0,          32'd3,          32'd1,          1'b1};
    vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[3]  = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[5]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[6]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[7]  = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
    vecs[8]  = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b0};
    vecs[9]  = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0};
    vecs[10] = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0};

    reset = 1'b1; DivCtrl = 1'b0; A = 32'd0; B = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    chk("reset DivOut", {31'd0, DivOut}, 32'd0);
    chk("reset divZero", {31'd0, divZero}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].zero);

    // Reset in the middle of an operation clears HI/LO and drops the operation.
    @(negedge clk);
    A = 32'd100; B = 32'd7; DivCtrl = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset HI", HI, 32'd0);
    chk("midreset LO", LO, 32'd0);
    chk("midreset DivOut", {31'd0, DivOut}, 32'd0);
    reset = 1'b0; DivCtrl = 1'b0;
    @(posedge clk);
    run_op("after reset", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Abort by dropping DivCtrl partway through CALC.
    run_op("pre abort", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
    begin
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      A = 32'd100; B = 32'd7; DivCtrl = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      DivCtrl = 1'b0;
      repeat (40) begin
        @(posedge clk);
        @(negedge clk);
        seen = seen | DivOut | divZero;
      end
      chk("abort no pulse", {31'd0, seen}, 32'd0);
      chk("abort LO", LO, 32'd3);
      chk("abort HI", HI, 32'd1);
    end

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, b, q, r;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 20);
      if ($urandom_range(0, 3) == 0) b = -b;
      if (b == 32'd0) begin
        run_op("rnd zero", a, b, m_lo, m_hi, 1'b1);
      end else begin
        ref_div(a, b, q, r);
        run_op("rnd", a, b, q, r, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
